// File: rtl/wb_stage.sv
// wb_stage - writeback stage of the RV32I core.
//
// Accepts one retiring instruction per in_valid/in_ready handshake. ALU results
// are written to the register file on the cycle after acceptance. Loads park
// the stage in WAIT_LOAD until the data memory answers. The returned word is
// then aligned and extended and written one cycle later. If no answer arrives
// within LOAD_TIMEOUT cycles, the load is abandoned and a sticky fault is raised.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   retire handshake (ready only while IDLE)
//   in_rd, in_wen       destination register and its write enable
//   in_is_load          1 = result comes from memory, 0 = in_alu_result
//   in_funct3           load width / sign code
//   in_addr_lo          load byte address bits [1:0]
//   in_alu_result       result for non-load instructions
//   mem_rvalid          single-cycle load-data strobe
//   mem_rdata           raw aligned word from data memory
//   rf_we/rf_wa/rf_wdata registered register-file write port
//   pending_valid/rd    destination of an outstanding load, for hazard stalls
//   load_fault          sticky: a load timed out
//   spurious_rvalid     sticky: mem_rvalid arrived while not waiting
//   retire_count        number of completed instructions (wraps)

module wb_stage #(
    parameter int LOAD_TIMEOUT = 16,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_rd,
    input  logic             in_wen,
    input  logic             in_is_load,
    input  logic [2:0]       in_funct3,
    input  logic [1:0]       in_addr_lo,
    input  logic [31:0]      in_alu_result,
    input  logic             mem_rvalid,
    input  logic [31:0]      mem_rdata,
    output logic             rf_we,
    output logic [4:0]       rf_wa,
    output logic [31:0]      rf_wdata,
    output logic             pending_valid,
    output logic [4:0]       pending_rd,
    output logic             load_fault,
    output logic             spurious_rvalid,
    output logic [CNT_W-1:0] retire_count
);

    typedef enum logic [0:0] {
        S_IDLE,
        S_WAIT_LOAD
    } state_t;

    // The wait counter starts at 0 in the first WAIT_LOAD cycle, so the last
    // cycle in which a response is still accepted is the one where it equals
    // LOAD_TIMEOUT-1.
    localparam logic [7:0] TIMEOUT_LAST = 8'(LOAD_TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [4:0]         rd_q, rd_d;
    logic               wen_q, wen_d;
    logic [2:0]         funct3_q, funct3_d;
    logic [1:0]         addr_lo_q, addr_lo_d;
    logic               rf_we_q, rf_we_d;
    logic [4:0]         rf_wa_q, rf_wa_d;
    logic [31:0]        rf_wdata_q, rf_wdata_d;
    logic               load_fault_q, load_fault_d;
    logic               spurious_q, spurious_d;
    logic [CNT_W-1:0]   retire_q, retire_d;

    // Select the addressed byte/halfword and extend it according to funct3.
    // The halfword select uses only addr_lo[1]; misaligned halfwords are
    // not this stage's concern. Reserved codes behave like LW.
    function automatic logic [31:0] align_load(input logic [2:0]  f3,
                                               input logic [1:0]  a,
                                               input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(d >> {a, 3'b000});
        h = 16'(d >> {a[1], 4'b0000});
        case (f3)
            3'b000:  align_load = {{24{b[7]}}, b};
            3'b001:  align_load = {{16{h[15]}}, h};
            3'b100:  align_load = {24'b0, b};
            3'b101:  align_load = {16'b0, h};
            default: align_load = d;
        endcase
    endfunction

    // Next-state and write-port logic. The write enable defaults to 0 each
    // cycle, so every write is a single-cycle pulse. The address and data
    // only change when a write is actually issued, so they hold otherwise.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rd_d         = rd_q;
        wen_d        = wen_q;
        funct3_d     = funct3_q;
        addr_lo_d    = addr_lo_q;
        rf_we_d      = 1'b0;
        rf_wa_d      = rf_wa_q;
        rf_wdata_d   = rf_wdata_q;
        load_fault_d = load_fault_q;
        spurious_d   = spurious_q | (mem_rvalid & (state_q == S_IDLE));
        retire_d     = retire_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (in_is_load) begin
                        rd_d      = in_rd;
                        wen_d     = in_wen;
                        funct3_d  = in_funct3;
                        addr_lo_d = in_addr_lo;
                        cnt_d     = 8'd0;
                        state_d   = S_WAIT_LOAD;
                    end else begin
                        rf_we_d  = in_wen & (in_rd != 5'd0);
                        retire_d = retire_q + CNT_W'(1);
                        if (rf_we_d) begin
                            rf_wa_d    = in_rd;
                            rf_wdata_d = in_alu_result;
                        end
                    end
                end
            end
            S_WAIT_LOAD: begin
                cnt_d = cnt_q + 8'd1;
                // A response in the final allowed cycle wins over the timeout.
                if (mem_rvalid) begin
                    rf_we_d  = wen_q & (rd_q != 5'd0);
                    retire_d = retire_q + CNT_W'(1);
                    state_d  = S_IDLE;
                    if (rf_we_d) begin
                        rf_wa_d    = rd_q;
                        rf_wdata_d = align_load(funct3_q, addr_lo_q, mem_rdata);
                    end
                end else if (cnt_q == TIMEOUT_LAST) begin
                    load_fault_d = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers. Reset in WAIT_LOAD simply returns to IDLE,
    // which drops the outstanding load without a write.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 8'd0;
            rd_q         <= 5'd0;
            wen_q        <= 1'b0;
            funct3_q     <= 3'd0;
            addr_lo_q    <= 2'd0;
            rf_we_q      <= 1'b0;
            rf_wa_q      <= 5'd0;
            rf_wdata_q   <= 32'd0;
            load_fault_q <= 1'b0;
            spurious_q   <= 1'b0;
            retire_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rd_q         <= rd_d;
            wen_q        <= wen_d;
            funct3_q     <= funct3_d;
            addr_lo_q    <= addr_lo_d;
            rf_we_q      <= rf_we_d;
            rf_wa_q      <= rf_wa_d;
            rf_wdata_q   <= rf_wdata_d;
            load_fault_q <= load_fault_d;
            spurious_q   <= spurious_d;
            retire_q     <= retire_d;
        end
    end

    // A load only counts as a pending hazard if it will really write a register.
    always_comb begin
        in_ready      = (state_q == S_IDLE);
        pending_valid = (state_q == S_WAIT_LOAD) & wen_q & (rd_q != 5'd0);
        pending_rd    = pending_valid ? rd_q : 5'd0;
    end

    assign rf_we           = rf_we_q;
    assign rf_wa           = rf_wa_q;
    assign rf_wdata        = rf_wdata_q;
    assign load_fault      = load_fault_q;
    assign spurious_rvalid = spurious_q;
    assign retire_count    = retire_q;

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage - self-checking bench for wb_stage.
//
// Stimulus tasks push every expected register-file write into a queue. An
// independent monitor pops the queue on each rf_we pulse and compares the
// address and data. Status outputs are checked directly from the main flow.

module tb_wb_stage;

    localparam int LOAD_TIMEOUT = 4;
    localparam int CNT_W        = 32;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       in_rd;
    logic             in_wen;
    logic             in_is_load;
    logic [2:0]       in_funct3;
    logic [1:0]       in_addr_lo;
    logic [31:0]      in_alu_result;
    logic             mem_rvalid;
    logic [31:0]      mem_rdata;
    logic             rf_we;
    logic [4:0]       rf_wa;
    logic [31:0]      rf_wdata;
    logic             pending_valid;
    logic [4:0]       pending_rd;
    logic             load_fault;
    logic             spurious_rvalid;
    logic [CNT_W-1:0] retire_count;

    typedef struct {
        logic [4:0]  wa;
        logic [31:0] wdata;
    } wr_exp_t;

    wr_exp_t expQ[$];
    int      testsRun;
    int      testsFailed;
    int      expRetire;

    wb_stage #(
        .LOAD_TIMEOUT(LOAD_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_rd          (in_rd),
        .in_wen         (in_wen),
        .in_is_load     (in_is_load),
        .in_funct3      (in_funct3),
        .in_addr_lo     (in_addr_lo),
        .in_alu_result  (in_alu_result),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .rf_we          (rf_we),
        .rf_wa          (rf_wa),
        .rf_wdata       (rf_wdata),
        .pending_valid  (pending_valid),
        .pending_rd     (pending_rd),
        .load_fault     (load_fault),
        .spurious_rvalid(spurious_rvalid),
        .retire_count   (retire_count)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends even if the flow below stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: every write pulse must match the oldest expectation.
    always @(negedge clk) begin
        wr_exp_t e;
        if (rf_we === 1'b1) begin
            if (expQ.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL unexpected_write: got wa=%0d data=0x%08h, expected no write",
                         rf_wa, rf_wdata);
            end else begin
                e = expQ.pop_front();
                checkOutput("rf_wa", 32'(rf_wa), 32'(e.wa));
                checkOutput("rf_wdata", rf_wdata, e.wdata);
            end
        end else if (rf_we !== 1'b0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL rf_we_unknown: got %b, expected 0 or 1", rf_we);
        end
    end

    // Move just past the falling edge, after the monitor has run.
    task automatic sampleNeg();
        @(negedge clk);
        #1;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one instruction for a single handshake cycle.
    task automatic applyStimulus(input logic [4:0] rd, input logic wen, input logic isLoad,
                                 input logic [2:0] f3, input logic [1:0] addrLo,
                                 input logic [31:0] alu);
        checkOutput("in_ready_at_issue", 32'(in_ready), 32'd1);
        in_valid      = 1'b1;
        in_rd         = rd;
        in_wen        = wen;
        in_is_load    = isLoad;
        in_funct3     = f3;
        in_addr_lo    = addrLo;
        in_alu_result = alu;
        @(posedge clk);
        #1;
        in_valid      = 1'b0;
    endtask

    task automatic issueAlu(input logic [4:0] rd, input logic wen, input logic [31:0] data);
        wr_exp_t e;
        if (wen && rd != 5'd0) begin
            e.wa    = rd;
            e.wdata = data;
            expQ.push_back(e);
        end
        expRetire++;
        applyStimulus(rd, wen, 1'b0, 3'd0, 2'd0, data);
    endtask

    task automatic issueLoad(input logic [4:0] rd, input logic wen, input logic [2:0] f3,
                             input logic [1:0] addrLo);
        applyStimulus(rd, wen, 1'b1, f3, addrLo, 32'h0);
    endtask

    // Return load data; expWrite says whether a register write must follow.
    task automatic respondLoad(input logic [31:0] data, input logic expWrite,
                               input logic [4:0] rd, input logic [31:0] expData);
        wr_exp_t e;
        if (expWrite) begin
            e.wa    = rd;
            e.wdata = expData;
            expQ.push_back(e);
        end
        expRetire++;
        mem_rvalid = 1'b1;
        mem_rdata  = data;
        @(posedge clk);
        #1;
        mem_rvalid = 1'b0;
    endtask

    task automatic checkIdleAfterWrite(input string name);
        sampleNeg();
        checkOutput({name, "_write_drained"}, 32'(expQ.size()), 32'd0);
        checkOutput({name, "_retire"}, retire_count, 32'(expRetire));
        checkOutput({name, "_in_ready"}, 32'(in_ready), 32'd1);
        checkOutput({name, "_pending_valid"}, 32'(pending_valid), 32'd0);
    endtask

    task automatic checkResetState(input string name, input logic expSpurious);
        checkOutput({name, "_rf_we"}, 32'(rf_we), 32'd0);
        checkOutput({name, "_rf_wa"}, 32'(rf_wa), 32'd0);
        checkOutput({name, "_rf_wdata"}, rf_wdata, 32'd0);
        checkOutput({name, "_pending_valid"}, 32'(pending_valid), 32'd0);
        checkOutput({name, "_pending_rd"}, 32'(pending_rd), 32'd0);
        checkOutput({name, "_load_fault"}, 32'(load_fault), 32'd0);
        checkOutput({name, "_spurious"}, 32'(spurious_rvalid), 32'(expSpurious));
        checkOutput({name, "_retire"}, retire_count, 32'd0);
        checkOutput({name, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        testsRun      = 0;
        testsFailed   = 0;
        expRetire     = 0;
        reset         = 1'b1;
        in_valid      = 1'b0;
        in_rd         = 5'd0;
        in_wen        = 1'b0;
        in_is_load    = 1'b0;
        in_funct3     = 3'd0;
        in_addr_lo    = 2'd0;
        in_alu_result = 32'd0;
        mem_rvalid    = 1'b0;
        mem_rdata     = 32'd0;
        waitCycles(2);
        reset = 1'b0;
        sampleNeg();
        checkResetState("reset", 1'b0);

        // Back-to-back ALU retirements.
        issueAlu(5'd5, 1'b1, 32'h12345678);
        issueAlu(5'd6, 1'b1, 32'hCAFEBABE);
        checkIdleAfterWrite("alu_pair");
        checkOutput("alu_pair_count2", retire_count, 32'd2);

        // LB from byte 3, answered in the last allowed wait cycle.
        issueLoad(5'd10, 1'b1, 3'b000, 2'd3);
        sampleNeg();
        checkOutput("lb_wait_in_ready", 32'(in_ready), 32'd0);
        checkOutput("lb_wait_pending_valid", 32'(pending_valid), 32'd1);
        checkOutput("lb_wait_pending_rd", 32'(pending_rd), 32'd10);
        waitCycles(2);
        sampleNeg();
        checkOutput("lb_wait3_pending_valid", 32'(pending_valid), 32'd1);
        checkOutput("lb_wait3_no_fault", 32'(load_fault), 32'd0);
        waitCycles(1);
        respondLoad(32'h80FF0011, 1'b1, 5'd10, 32'hFFFFFF80);
        checkIdleAfterWrite("lb");
        checkOutput("lb_no_fault", 32'(load_fault), 32'd0);

        // Halfword and other widths, answered at the earliest possible cycle.
        issueLoad(5'd11, 1'b1, 3'b101, 2'd2);
        respondLoad(32'h80011234, 1'b1, 5'd11, 32'h00008001);
        checkIdleAfterWrite("lhu");
        issueLoad(5'd12, 1'b1, 3'b001, 2'd2);
        respondLoad(32'h80011234, 1'b1, 5'd12, 32'hFFFF8001);
        checkIdleAfterWrite("lh");
        issueLoad(5'd13, 1'b1, 3'b100, 2'd2);
        respondLoad(32'h80FF0011, 1'b1, 5'd13, 32'h000000FF);
        checkIdleAfterWrite("lbu");
        issueLoad(5'd14, 1'b1, 3'b011, 2'd1);
        respondLoad(32'h80FF0011, 1'b1, 5'd14, 32'h80FF0011);
        checkIdleAfterWrite("lw_reserved");

        // Instructions that retire without writing.
        issueLoad(5'd0, 1'b1, 3'b010, 2'd0);
        sampleNeg();
        checkOutput("rd0_pending_valid", 32'(pending_valid), 32'd0);
        checkOutput("rd0_pending_rd", 32'(pending_rd), 32'd0);
        respondLoad(32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
        issueAlu(5'd9, 1'b0, 32'h11111111);
        checkIdleAfterWrite("nowrite");
        checkOutput("nowrite_count", retire_count, 32'd9);

        // Timeout: no response for LOAD_TIMEOUT cycles.
        issueLoad(5'd15, 1'b1, 3'b010, 2'd0);
        waitCycles(LOAD_TIMEOUT - 1);
        sampleNeg();
        checkOutput("timeout_last_cycle_fault", 32'(load_fault), 32'd0);
        checkOutput("timeout_last_cycle_in_ready", 32'(in_ready), 32'd0);
        waitCycles(1);
        sampleNeg();
        checkOutput("timeout_fault", 32'(load_fault), 32'd1);
        checkOutput("timeout_in_ready", 32'(in_ready), 32'd1);
        checkOutput("timeout_retire", retire_count, 32'(expRetire));
        checkOutput("timeout_spurious", 32'(spurious_rvalid), 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h55555555;
        waitCycles(1);
        mem_rvalid = 1'b0;
        sampleNeg();
        checkOutput("spurious_set", 32'(spurious_rvalid), 32'd1);
        checkOutput("spurious_retire", retire_count, 32'(expRetire));
        checkOutput("spurious_fault_sticky", 32'(load_fault), 32'd1);

        // Reset on the second wait cycle drops the load.
        issueLoad(5'd7, 1'b1, 3'b010, 2'd0);
        waitCycles(1);
        reset = 1'b1;
        waitCycles(1);
        reset      = 1'b0;
        expRetire  = 0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h77777777;
        waitCycles(1);
        mem_rvalid = 1'b0;
        sampleNeg();
        checkResetState("reset_in_wait", 1'b1);

        // The stage keeps working after that reset.
        issueAlu(5'd3, 1'b1, 32'hA5A5A5A5);
        checkIdleAfterWrite("post_reset");

        waitCycles(2);
        checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the RV32I core; the writer end of the register-file write port (we/wa/wdata).
- Accepts one retiring instruction per handshake from the execute/memory stage.
- For loads, waits a variable number of cycles for the data-memory response, then aligns and sign-extends it.
- Issues a registered single-cycle register-file write, and exports pending-destination info for hazard stalling.

Parameters:
- LOAD_TIMEOUT, 16, cycles to wait in WAIT_LOAD before aborting the load; legal range 1..255.
- CNT_W, 32, width of retire_count.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  retiring instruction presented
- in_ready  out  1  stage can accept; combinational from state (1 only in IDLE)
- in_rd  in  5  destination register
- in_wen  in  1  instruction writes rd
- in_is_load  in  1  1 = load (result from memory), 0 = in_alu_result
- in_funct3  in  3  load width/sign code
- in_addr_lo  in  2  load address bits [1:0]
- in_alu_result  in  32  result for non-loads
- mem_rvalid  in  1  load data valid, single-cycle pulse
- mem_rdata  in  32  raw aligned-word load data
- rf_we  out  1  register-file write enable, registered
- rf_wa  out  5  register-file write address, registered
- rf_wdata  out  32  register-file write data, registered
- pending_valid  out  1  load in WAIT_LOAD with wen=1 and rd!=0
- pending_rd  out  5  rd of that load; 0 when pending_valid=0
- load_fault  out  1  sticky: a load timed out
- spurious_rvalid  out  1  sticky: mem_rvalid seen outside WAIT_LOAD
- retire_count  out  CNT_W  completed instructions

Behaviour:
- Reset values: state=IDLE, rf_we=0, rf_wa=0, rf_wdata=0, pending_valid=0, pending_rd=0, load_fault=0, spurious_rvalid=0, retire_count=0, timeout counter=0.
- Reset during WAIT_LOAD drops the load; no write is issued for it.
- States: IDLE, WAIT_LOAD.
- IDLE: in_ready=1. Handshake = in_valid & in_ready.
  - Non-load accepted: next cycle rf_we=(in_wen & in_rd!=0), rf_wa=in_rd, rf_wdata=in_alu_result. retire_count+1. Stay IDLE; back-to-back accepts give one write per cycle.
  - Load accepted: latch rd, wen, funct3, addr_lo; timeout counter=0; go to WAIT_LOAD. rf_we=0 next cycle.
- WAIT_LOAD: in_ready=0; counter +1 per cycle.
  - mem_rvalid=1: next cycle rf_we=(wen & rd!=0), rf_wa=rd, rf_wdata=aligned data. retire_count+1. Go to IDLE; new accept possible that same next cycle.
  - mem_rvalid=0 and counter reaches LOAD_TIMEOUT-1: set load_fault, no write, no retire increment, go to IDLE.
  - mem_rvalid in the timeout cycle: treated as a response, not a fault.
  - Earliest valid response is the cycle after load acceptance.
- When rf_we=0, rf_wa and rf_wdata hold their last values.
- mem_rvalid in IDLE: ignored for data; set spurious_rvalid.
- Load alignment: byte = mem_rdata[8*addr_lo +: 8]; half = mem_rdata[16*addr_lo[1] +: 16]; addr_lo[0] is ignored for halfwords, and misalignment is not checked here.
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend half.
  - 010 LW: full word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
  - 011/110/111: treated as LW.
- retire_count wraps modulo 2^CNT_W. Sticky flags clear only on reset.
- Load latency from mem_rvalid to rf_we = 1 cycle; ALU latency from accept to rf_we = 1 cycle.

Test Plan:
- Reset, then ALU accepts rd=5 data=0x12345678 and rd=6 data=0xCAFEBABE on consecutive cycles -> rf_we high 2 consecutive cycles with (5,0x12345678) then (6,0xCAFEBABE); retire_count=2.
- LB, addr_lo=3, mem_rdata=0x80FF0011 after 4 wait cycles -> in_ready=0 and pending_valid=1, pending_rd=rd while waiting; write 0xFFFFFF80 one cycle after mem_rvalid.
- LHU, addr_lo=2, mem_rdata=0x8001_1234 -> write 0x00008001; LH same data -> write 0xFFFF8001.
- Load with rd=0, and ALU op with in_wen=0 -> no rf_we pulse; retire_count increments by 2; pending_valid stays 0.
- LOAD_TIMEOUT=4, no mem_rvalid -> load_fault=1 after 4 WAIT_LOAD cycles, no write, retire_count unchanged, in_ready=1 next cycle; a later mem_rvalid in IDLE sets spurious_rvalid.
- reset asserted on the 2nd WAIT_LOAD cycle, then mem_rvalid -> all outputs at reset values, no write, spurious_rvalid=1.
